button_event_ctrl: RTL and testbench

// Debounces NUM_BUTTONS raw buttons and turns each into PRESS/LONG/REPEAT/RELEASE events.
// All buttons share one tick prescaler. One event stream comes out through a valid/ready port.
// A round-robin arbiter picks which button's event goes out next.

---
 rtl/button_event_ctrl_pkg.sv | 19 +
 rtl/button_event_ctrl_channel.sv | 116 +++++++++++
 rtl/button_event_ctrl.sv | 132 +++++++++++++
 tb/tb_button_event_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared event and channel-state encodings for the button event controller.
// Consumers import this package to decode evt_kind.
package button_event_ctrl_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_REPEAT   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_event_ctrl_channel.sv
// One button: 2-flop synchroniser, debounce/long/repeat FSM, debounced level.
// emit/kind are combinational and valid in the cycle the FSM transitions.
module button_channel
  import button_event_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH      = 10,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       but,
  input  logic       tick,
  output logic       butd,
  output logic       emit,
  output logic [1:0] kind
);

  localparam logic [CNT_WIDTH-1:0] DEB_LAST =
    CNT_WIDTH'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST =
    CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REP_LAST =
    CNT_WIDTH'(REPEAT_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  logic s1, s2;
  btn_state_e state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic butd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
      butd  <= 1'b0;
    end else begin
      s1    <= but;
      s2    <= s1;
      state <= state_d;
      cnt   <= cnt_d;
      butd  <= butd_d;
    end
  end

  // A falling synchronised input wins over a tick in the same cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    butd_d  = butd;
    emit    = 1'b0;
    kind    = EVT_PRESS;
    unique case (state)
      ST_IDLE: begin
        if (s2) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!s2) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (cnt == DEB_LAST) begin
            state_d = ST_HELD;
            butd_d  = 1'b1;
            emit    = 1'b1;
            kind    = EVT_PRESS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
      end
      ST_HELD: begin
        if (!s2) begin
          state_d = ST_IDLE;
          butd_d  = 1'b0;
          emit    = 1'b1;
          kind    = EVT_RELEASE;
        end else if (tick) begin
          if (cnt == LONG_LAST) begin
            state_d = ST_REPEAT;
            emit    = 1'b1;
            kind    = EVT_LONG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
      end
      ST_REPEAT: begin
        if (!s2) begin
          state_d = ST_IDLE;
          butd_d  = 1'b0;
          emit    = 1'b1;
          kind    = EVT_RELEASE;
        end else if (tick) begin
          if (cnt == REP_LAST) begin
            emit  = 1'b1;
            kind  = EVT_REPEAT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-button debouncer with shared prescaler, 1-deep pending slots
// and a round-robin arbiter feeding one valid/ready event port.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int NUM_BUTTONS    = 4,
  parameter int TICK_WIDTH     = 14,
  parameter logic [TICK_WIDTH-1:0] TICK_TOTAL = 14'd12000,
  parameter int CNT_WIDTH      = 10,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100,
  localparam int IW = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] but,
  output logic [NUM_BUTTONS-1:0] butd,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IW-1:0]          evt_button,
  output logic [1:0]             evt_kind,
  output logic                   evt_drop
);

  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_TOTAL - 1'b1;

  logic [TICK_WIDTH-1:0] presc;
  logic tick;
  logic [NUM_BUTTONS-1:0] emit;
  logic [1:0] ckind [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] pend;
  logic [1:0] pkind [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] hit;
  logic [NUM_BUTTONS-1:0] drop;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] gi;
  logic found;
  logic load;
  int idx;

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_ch
    button_channel #(
      .CNT_WIDTH      (CNT_WIDTH),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .but  (but[b]),
      .tick (tick),
      .butd (butd[b]),
      .emit (emit[b]),
      .kind (ckind[b])
    );
  end

  // Scan starts one past the last grant so every button gets a turn.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    gi    = '0;
    for (int k = 1; k <= NUM_BUTTONS; k++) begin
      idx = (int'(ptr) + k) % NUM_BUTTONS;
      gi  = IW'(idx);
      if (!found && pend[gi]) begin
        found = 1'b1;
        grant = gi;
      end
    end
  end

  assign load = (!evt_valid || evt_ready) && (|pend);

  always_comb begin
    hit  = '0;
    drop = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      hit[i]  = load && (grant == IW'(i));
      drop[i] = emit[i] && pend[i] && !hit[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) pkind[i] <= EVT_PRESS;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (emit[i]) begin
          if (!(drop[i] && ckind[i] == EVT_REPEAT)) begin
            pend[i]  <= 1'b1;
            pkind[i] <= ckind[i];
          end
        end else if (hit[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_button <= '0;
      evt_kind   <= EVT_PRESS;
      evt_drop   <= 1'b0;
      ptr        <= IW'(NUM_BUTTONS - 1);
    end else begin
      evt_drop <= |drop;
      if (load) begin
        evt_valid  <= 1'b1;
        evt_button <= grant;
        evt_kind   <= pkind[grant];
        ptr        <= grant;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed and random stimulus for button_event_ctrl, checked every cycle
// against a tick-count based reference model of the event stream.
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int TT = 4;
  localparam int D  = 3;
  localparam int L  = 5;
  localparam int R  = 2;
  localparam int K_PRESS   = 0;
  localparam int K_LONG    = 1;
  localparam int K_REPEAT  = 2;
  localparam int K_RELEASE = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] but;
  logic [N-1:0] butd;
  logic evt_valid;
  logic evt_ready;
  logic [1:0] evt_button;
  logic [1:0] evt_kind;
  logic evt_drop;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NUM_BUTTONS    (N),
    .TICK_WIDTH     (14),
    .TICK_TOTAL     (14'd4),
    .CNT_WIDTH      (10),
    .DEBOUNCE_TICKS (D),
    .LONG_TICKS     (L),
    .REPEAT_TICKS   (R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .but        (but),
    .butd       (butd),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_button (evt_button),
    .evt_kind   (evt_kind),
    .evt_drop   (evt_drop)
  );

  // Reference model state: s is the raw input delayed two clocks, and
  // n counts ticks seen since s went high (events fire at fixed n).
  int m_s1 [N];
  int m_s2 [N];
  int m_act [N];
  int m_n [N];
  int m_butd [N];
  int m_pend [N];
  int m_pk [N];
  int m_valid, m_btn, m_kind, m_drop, m_ptr, m_pc;

  task automatic model_cycle(input logic r, input logic [N-1:0] b,
                             input logic rd);
    int e [N];
    int ek [N];
    int tk, ld, g, nn, outk;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_act[i] = 0; m_n[i] = 0;
        m_butd[i] = 0; m_pend[i] = 0; m_pk[i] = 0;
      end
      m_valid = 0; m_btn = 0; m_kind = 0; m_drop = 0;
      m_ptr = N - 1; m_pc = 0;
      return;
    end
    tk = (m_pc == TT - 1) ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      e[i] = 0; ek[i] = 0;
      if (m_s2[i] != 0 && m_act[i] == 0) begin
        m_act[i] = 1; m_n[i] = 0;
      end else if (m_s2[i] != 0 && tk != 0) begin
        nn = m_n[i] + 1;
        if (nn == D) begin e[i] = 1; ek[i] = K_PRESS; end
        else if (nn == D + L) begin e[i] = 1; ek[i] = K_LONG; end
        else if (nn > D + L && (nn - D - L) % R == 0) begin
          e[i] = 1; ek[i] = K_REPEAT;
        end
        m_n[i] = nn;
      end else if (m_s2[i] == 0 && m_act[i] != 0) begin
        if (m_n[i] >= D) begin e[i] = 1; ek[i] = K_RELEASE; end
        m_act[i] = 0; m_n[i] = 0;
      end
      m_butd[i] = (m_act[i] != 0 && m_n[i] >= D) ? 1 : 0;
      m_s2[i] = m_s1[i];
      m_s1[i] = int'(b[i]);
    end
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && m_pend[(m_ptr + k) % N] != 0) g = (m_ptr + k) % N;
    ld = (g >= 0 && (m_valid == 0 || rd)) ? 1 : 0;
    outk = (g >= 0) ? m_pk[g] : 0;
    m_drop = 0;
    for (int i = 0; i < N; i++) begin
      if (ld != 0 && i == g) m_pend[i] = 0;
      if (e[i] != 0) begin
        if (m_pend[i] != 0) begin
          m_drop = 1;
          if (ek[i] != K_REPEAT) m_pk[i] = ek[i];
        end else begin
          m_pend[i] = 1; m_pk[i] = ek[i];
        end
      end
    end
    if (ld != 0) begin
      m_valid = 1; m_btn = g; m_kind = outk; m_ptr = g;
    end else if (rd) begin
      m_valid = 0;
    end
    m_pc = (m_pc + 1) % TT;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic r;
    logic [N-1:0] b;
    logic rd;
    r = rst; b = but; rd = evt_ready;
    @(posedge clk);
    model_cycle(r, b, rd);
    #1;
    for (int i = 0; i < N; i++)
      chk("butd", 32'(butd[i]), 32'(m_butd[i]));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_drop", 32'(evt_drop), 32'(m_drop));
    if (m_valid != 0) begin
      chk("evt_button", 32'(evt_button), 32'(m_btn));
      chk("evt_kind", 32'(evt_kind), 32'(m_kind));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int hold [N];
  int seen;

  initial begin
    rst = 1'b1; but = '0; evt_ready = 1'b1;
    run(2);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_butd", 32'(butd), 32'd0);
    chk("rst_button", 32'(evt_button), 32'd0);
    chk("rst_kind", 32'(evt_kind), 32'd0);
    chk("rst_drop", 32'(evt_drop), 32'd0);
    rst = 1'b0;
    run(3);

    // long press with LONG and REPEATs
    but[1] = 1'b1; run(40);
    but[1] = 1'b0; run(12);
    chk("b1_released", 32'(butd[1]), 32'd0);

    // glitchy input on button 2
    but[2] = 1'b1; run(6);
    but[2] = 1'b0; run(2);
    but[2] = 1'b1; run(6);
    but[2] = 1'b0; run(12);
    chk("glitch_butd", 32'(butd[2]), 32'd0);

    // simultaneous presses
    but[0] = 1'b1; but[3] = 1'b1; run(20);
    but[0] = 1'b0; but[3] = 1'b0; run(10);
    but[1] = 1'b1; but[2] = 1'b1; run(20);
    but[1] = 1'b0; but[2] = 1'b0; run(10);

    // backpressure while held past LONG
    evt_ready = 1'b0; but[1] = 1'b1; run(200);
    evt_ready = 1'b1; run(10);
    but[1] = 1'b0; run(12);

    // reset while an event is held and button 2 is in HELD
    but[2] = 1'b1; run(2);
    evt_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      step();
      if (evt_valid === 1'b1) seen = 1;
    end
    compared++;
    assert (seen == 1) else begin
      mismatched++;
      $error("FAIL wait_press: observed %0d expected 1", seen);
    end
    rst = 1'b1; run(1);
    rst = 1'b0;
    chk("rst_mid_valid", 32'(evt_valid), 32'd0);
    chk("rst_mid_butd", 32'(butd), 32'd0);
    evt_ready = 1'b1;
    run(30);
    chk("fresh_press_butd", 32'(butd[2]), 32'd1);
    but[2] = 1'b0; run(10);

    // random buttons and ready
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          but[i] = ~but[i];
          hold[i] = $urandom_range(1, 50);
        end else begin
          hold[i]--;
        end
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      rst = (c == 1500);
      step();
    end
    rst = 1'b0; but = '0; evt_ready = 1'b1;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
